regwrite_arbiter: RTL and testbench
===================================

# regwrite_arbiter

Arbitrates the single register-file write port between the pipeline writeback stage and a long-latency result producer (multiply/divide, uncached load return). Pipeline writes always win. Long-latency results are buffered in a small FIFO and drained in cycles where writeback does not use the port. Sits between writeback, the long-latency unit, and the register file. Exports a pending-write mask for the hazard unit.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- arm  in  1  1 = ARM mode, 0 = RV mode (x0 hardwired zero)
- RegWriteW  in  1  pipeline writeback write enable
- RdW  in  5  pipeline destination register
- ResultW  in  32  pipeline writeback data
- LongValid  in  1  long-latency result valid
- LongRd  in  5  long-latency destination
- LongData  in  32  long-latency data
- LongReady  out  1  arbiter can accept a long result
- WE3  out  1  register-file write enable
- A3  out  5  register-file write address
- WD3  out  32  register-file write data
- PendingMask  out  32  bit r set while a live queued write to r exists

## Operation
- Effective pipeline write: PW = RegWriteW & ~(~arm & RdW==0).
- Long transfer: LongValid & LongReady, sampled at posedge. In RV mode, LongRd==0 is accepted and discarded, not enqueued.
- FIFO entry = {live, rd, data}. Enqueue writes the entry at the tail with live=1.
- Kill rule: the long op is older than the instruction in W, so when PW=1, the younger pipeline write wins:
  - every queued entry with rd==RdW gets live=0;
  - a same-cycle enqueue with LongRd==RdW is stored with live=0.
- Port select:
  - PW=1: WE3=1, A3=RdW, WD3=ResultW; FIFO head is held.
  - PW=0 and FIFO non-empty: head is popped. WE3=head.live, A3=head.rd, WD3=head.data. A dead head still consumes the cycle, with no write.
  - Otherwise: WE3=0, A3/WD3 = don't-care (driven 0).
- LongReady = (count < DEPTH). Registered-state only; no combinational path from PW or a pop.
- PendingMask is combinational from entry state: OR over live entries of onehot(rd).
- Simultaneous enqueue and pop when full is impossible, because LongReady=0. Simultaneous enqueue and pop otherwise: count unchanged, pointers wrap modulo DEPTH.

## Timing
- Port outputs are combinational from inputs and FIFO head: 0-cycle latency for pipeline writes.
- A long result is written no earlier than the cycle after acceptance. With bypass, see Configuration.
- PendingMask bit rises the cycle after acceptance. It falls the cycle after the entry pops or is killed.
- Reset (async, any cycle, mid-drain included): count=0, pointers=0, all live=0.
  - While rst=1: WE3=0, A3=0, WD3=0, LongReady=0, PendingMask=0.
  - After rst falls: LongReady=1.
- Wrap-around: head/tail pointers are log2(DEPTH) bits. count is log2(DEPTH)+1 bits.

## Configuration
- REGWRITE_ARB_BYPASS_EN defined:
  - A transfer with count==0 and PW=0 writes the port in the same cycle (WE3=1, A3=LongRd, WD3=LongData) and is not enqueued.
  - RV x0 writes are still dropped.
- Undefined: every transfer is enqueued. Minimum long-write latency is 1 cycle.

## Test plan
- Reset mid-drain: 3 entries queued, assert rst → outputs 0 immediately. After release: LongReady=1, PendingMask=0, no stale writes.
- Contention: RegWriteW=1 every cycle (RdW=5); push LongRd=7, 0xAAAA0001 → held, PendingMask[7]=1. Drop RegWriteW → next cycle WE3=1, A3=7, WD3=0xAAAA0001.
- Full: DEPTH=4, RegWriteW=1 continuously; 4 pushes → LongReady=0 and 5th LongValid held. One free cycle → pop, then LongReady=1.
- Kill: queue rd=9 (0x11); pipeline writes rd=9 (0x22) → entry dead, PendingMask[9]=0. Later drain → no WE3 for that entry; x9 keeps 0x22.
- RV x0: arm=0, push LongRd=0 → nothing queued. RegWriteW=1, RdW=0 with a queued entry → entry drains that cycle. Same with arm=1 → the x0 write wins the port.
- Bypass: with REGWRITE_ARB_BYPASS_EN, empty FIFO, PW=0, push rd=3 → WE3 same cycle, PendingMask stays 0. Without the macro → WE3 next cycle.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results queue in a FIFO.
// Optional same-cycle bypass of an empty FIFO is enabled by defining REGWRITE_ARB_BYPASS_EN.
module regwrite_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        LongValid,
    input  logic [4:0]  LongRd,
    input  logic [31:0] LongData,
    output logic        LongReady,
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic [31:0] PendingMask
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW:0]      count;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [DEPTH-1:0] live;
    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic pw;
    logic empty;
    logic xfer;
    logic drop;
    logic bypass;
    logic enq;
    logic pop;
    logic enq_live;

    assign empty = (count == '0);
    assign pw    = RegWriteW & ~(~arm & (RdW == 5'd0));

    // Ready depends only on registered occupancy (and reset), never on this cycle's port use.
    assign LongReady = ~rst & (count < DEPTH_C);
    assign xfer      = LongValid & LongReady;
    assign drop      = ~arm & (LongRd == 5'd0);

`ifdef REGWRITE_ARB_BYPASS_EN
    assign bypass = xfer & ~drop & empty & ~pw;
`else
    assign bypass = 1'b0;
`endif

    assign enq      = xfer & ~drop & ~bypass;
    assign pop      = ~pw & ~empty;
    // A younger pipeline write to the same register makes the arriving long result obsolete.
    assign enq_live = ~(pw & (LongRd == RdW));

    always_comb begin
        WE3 = 1'b0;
        A3  = 5'd0;
        WD3 = 32'd0;
        if (!rst) begin
            if (pw) begin
                WE3 = 1'b1;
                A3  = RdW;
                WD3 = ResultW;
            end else if (!empty) begin
                WE3 = live[head];
                A3  = rd_mem[head];
                WD3 = data_mem[head];
            end else if (bypass) begin
                WE3 = 1'b1;
                A3  = LongRd;
                WD3 = LongData;
            end
        end
    end

    always_comb begin
        PendingMask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) PendingMask[rd_mem[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            live  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pw && rd_mem[i] == RdW) live[i] <= 1'b0;
            end
            // Pop never coincides with a kill (pop needs pw=0), and enqueue never targets the head slot.
            if (pop) begin
                live[head] <= 1'b0;
                head       <= head + 1'b1;
            end
            if (enq) begin
                live[tail] <= enq_live;
                tail       <= tail + 1'b1;
            end
            case ({enq, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[tail]   <= LongRd;
            data_mem[tail] <= LongData;
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: a queue-based reference model predicts each cycle's port outputs.
// Honors REGWRITE_ARB_BYPASS_EN the same way the design does.
module tb_regwrite_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b1;
    logic        RegWriteW = 1'b0;
    logic [4:0]  RdW = 5'd0;
    logic [31:0] ResultW = 32'd0;
    logic        LongValid = 1'b0;
    logic [4:0]  LongRd = 5'd0;
    logic [31:0] LongData = 32'd0;
    logic        LongReady;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] PendingMask;

    regwrite_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .arm(arm),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .LongValid(LongValid), .LongRd(LongRd), .LongData(LongData),
        .LongReady(LongReady), .WE3(WE3), .A3(A3), .WD3(WD3),
        .PendingMask(PendingMask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic        ready;
        logic [31:0] mask;
    } exp_t;

    entry_t model_q[$];
    exp_t   exp_q[$];
    int     tests = 0;
    int     fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, predict this cycle's outputs, then advance the model past the next edge.
    task automatic step(input logic r, input logic a, input logic rw, input logic [4:0] rdw,
                        input logic [31:0] resw, input logic lv, input logic [4:0] lrd,
                        input logic [31:0] ld);
        exp_t e;
        logic pw, ready, xfer, drop, byp;
        @(posedge clk);
        #1;
        rst = r; arm = a; RegWriteW = rw; RdW = rdw; ResultW = resw;
        LongValid = lv; LongRd = lrd; LongData = ld;
        e = '0;
        if (r) begin
            model_q.delete();
        end else begin
            pw    = rw && !(!a && rdw == 5'd0);
            ready = model_q.size() < DEPTH;
            xfer  = lv && ready;
            drop  = !a && lrd == 5'd0;
            byp   = 1'b0;
`ifdef REGWRITE_ARB_BYPASS_EN
            byp   = xfer && !drop && model_q.size() == 0 && !pw;
`endif
            e.ready = ready;
            foreach (model_q[i]) if (model_q[i].live) e.mask[model_q[i].rd] = 1'b1;
            if (pw) begin
                e.we = 1'b1; e.a = rdw; e.d = resw;
            end else if (model_q.size() > 0) begin
                e.we = model_q[0].live; e.a = model_q[0].rd; e.d = model_q[0].data;
            end else if (byp) begin
                e.we = 1'b1; e.a = lrd; e.d = ld;
            end
            if (pw) begin
                foreach (model_q[i]) if (model_q[i].rd == rdw) model_q[i].live = 1'b0;
            end else if (model_q.size() > 0) begin
                void'(model_q.pop_front());
            end
            if (xfer && !drop && !byp)
                model_q.push_back('{live: !(pw && lrd == rdw), rd: lrd, data: ld});
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic a);
        step(1'b0, a, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("WE3", {31'd0, WE3}, {31'd0, e.we});
            chk("A3", {27'd0, A3}, {27'd0, e.a});
            chk("WD3", WD3, e.d);
            chk("LongReady", {31'd0, LongReady}, {31'd0, e.ready});
            chk("PendingMask", PendingMask, e.mask);
        end
    end

    initial begin
        logic        r, a, rw, lv;
        logic [4:0]  rdw, lrd;

        // Reset state
        step(1'b1, 1'b1, 1'b1, 5'd5, 32'h5, 1'b1, 5'd7, 32'h7);
        step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(1'b1);

        // Contention: pipeline holds the port while rd=7 waits
        step(1'b0, 1'b1, 1'b1, 5'd5, 32'h55, 1'b1, 5'd7, 32'hAAAA0001);
        step(1'b0, 1'b1, 1'b1, 5'd5, 32'h56, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 5'd5, 32'h57, 1'b0, 5'd0, 32'd0);
        idle(1'b1);
        idle(1'b1);

        // Full FIFO with the 5th request held
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b1, 5'd5, 32'h100 + i, 1'b1, 5'(10 + i), 32'hB000 + i);
        step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'hB004);
        step(1'b0, 1'b1, 1'b1, 5'd5, 32'h200, 1'b1, 5'd14, 32'hB004);
        repeat (6) idle(1'b1);

        // Kill: younger pipeline write to x9 supersedes the queued one
        step(1'b0, 1'b1, 1'b1, 5'd5, 32'h1, 1'b1, 5'd9, 32'h11);
        step(1'b0, 1'b1, 1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 5'd9, 32'h33, 1'b1, 5'd9, 32'h44);
        repeat (3) idle(1'b1);

        // RV x0 handling, then ARM r0 winning the port
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        step(1'b0, 1'b0, 1'b1, 5'd5, 32'h5, 1'b1, 5'd4, 32'h44);
        step(1'b0, 1'b0, 1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 5'd5, 32'h5, 1'b1, 5'd4, 32'h45);
        step(1'b0, 1'b1, 1'b1, 5'd0, 32'h98, 1'b0, 5'd0, 32'd0);
        repeat (2) idle(1'b1);

        // Empty FIFO, free port: bypass or next-cycle write
        step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3333);
        repeat (2) idle(1'b1);

        // Reset mid-drain
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b1, 5'd5, 32'h5, 1'b1, 5'(20 + i), 32'hC000 + i);
        idle(1'b1);
        step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h6);
        repeat (3) idle(1'b1);

        // Randomized traffic with narrow register ranges to force collisions
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            a   = ($urandom_range(0, 3) != 0);
            rw  = ($urandom_range(0, 99) < 55);
            lv  = ($urandom_range(0, 99) < 45);
            rdw = 5'($urandom_range(0, 7));
            lrd = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) lrd = 5'($urandom);
            step(r, a, rw, rdw, $urandom, lv, lrd, $urandom);
        end
        repeat (4) idle(1'b1);

        @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
